// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin sharing of one ALU datapath between NUM_REQ requesters.
// Define ALU_ARB_TIMEOUT_EN to add a done-wait timeout that answers with rsp_err=1.
module alu_req_arbiter #(
  parameter int NUM_REQ              = 4,
  parameter int ALU_OP_WIDTH         = 3,
  parameter int ALU_IN_WIDTH         = 8,
  parameter int ALU_OUT_RESULT_WIDTH = 16,
  parameter int TIMEOUT_CYCLES       = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*ALU_OP_WIDTH-1:0]  req_op,
  input  logic [NUM_REQ*ALU_IN_WIDTH-1:0]  req_a,
  input  logic [NUM_REQ*ALU_IN_WIDTH-1:0]  req_b,
  output logic                             alu_valid,
  input  logic                             alu_ready,
  output logic [ALU_OP_WIDTH-1:0]          alu_op,
  output logic [ALU_IN_WIDTH-1:0]          alu_a,
  output logic [ALU_IN_WIDTH-1:0]          alu_b,
  input  logic                             alu_done,
  input  logic [ALU_OUT_RESULT_WIDTH-1:0]  alu_result,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [ALU_OUT_RESULT_WIDTH-1:0]  rsp_result,
  output logic                             rsp_err,
  output logic                             busy
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0]                      state_reg;
  logic [1:0]                      state_next;
  logic [GW-1:0]                   last_grant_reg;
  logic [GW-1:0]                   grant_idx;
  logic                            grant_any;
  logic [NUM_REQ-1:0]              hi_mask;
  logic [NUM_REQ-1:0]              hi_req;
  logic [NUM_REQ-1:0]              pick_vec;
  logic [NUM_REQ-1:0]              grant_oh;
  logic [NUM_REQ-1:0]              owner_oh;
  logic [ALU_OP_WIDTH-1:0]         op_arr [NUM_REQ];
  logic [ALU_IN_WIDTH-1:0]         a_arr  [NUM_REQ];
  logic [ALU_IN_WIDTH-1:0]         b_arr  [NUM_REQ];
  logic                            alu_valid_reg;
  logic [ALU_OP_WIDTH-1:0]         alu_op_reg;
  logic [ALU_IN_WIDTH-1:0]         alu_a_reg;
  logic [ALU_IN_WIDTH-1:0]         alu_b_reg;
  logic [NUM_REQ-1:0]              rsp_valid_reg;
  logic [ALU_OUT_RESULT_WIDTH-1:0] rsp_result_reg;
  logic                            issue_fire;
  logic                            done_take;
  logic                            timeout_hit;

  // Unpack the requester buses and build the round-robin masks.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign op_arr[gi]   = req_op[gi*ALU_OP_WIDTH +: ALU_OP_WIDTH];
      assign a_arr[gi]    = req_a[gi*ALU_IN_WIDTH +: ALU_IN_WIDTH];
      assign b_arr[gi]    = req_b[gi*ALU_IN_WIDTH +: ALU_IN_WIDTH];
      assign hi_mask[gi]  = (last_grant_reg < GW'(gi));
      assign grant_oh[gi] = (grant_idx == GW'(gi));
      assign owner_oh[gi] = (last_grant_reg == GW'(gi));
    end
  endgenerate

  // Requests above the last grant win; otherwise wrap to the lowest pending one.
  assign grant_any = |req_valid;
  assign hi_req    = req_valid & hi_mask;
  assign pick_vec  = (|hi_req) ? hi_req : req_valid;

  always_comb begin
    grant_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (pick_vec[k]) begin
        grant_idx = GW'(k);
      end
    end
  end

  assign issue_fire = (state_reg == ST_ISSUE) && alu_ready;
  assign done_take  = alu_done && (issue_fire || (state_reg == ST_WAIT));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (grant_any) begin
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (issue_fire) begin
          state_next = done_take ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (done_take || timeout_hit) begin
          state_next = ST_RESP;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= GW'(NUM_REQ - 1);
      alu_valid_reg  <= 1'b0;
      alu_op_reg     <= '0;
      alu_a_reg      <= '0;
      alu_b_reg      <= '0;
      rsp_valid_reg  <= '0;
      rsp_result_reg <= '0;
    end else begin
      state_reg     <= state_next;
      rsp_valid_reg <= '0;
      if ((state_reg == ST_IDLE) && grant_any) begin
        last_grant_reg <= grant_idx;
        alu_valid_reg  <= 1'b1;
        alu_op_reg     <= op_arr[grant_idx];
        alu_a_reg      <= a_arr[grant_idx];
        alu_b_reg      <= b_arr[grant_idx];
      end
      if (issue_fire) begin
        alu_valid_reg <= 1'b0;
      end
      // last_grant_reg still names the owner of the in-flight operation.
      if (done_take) begin
        rsp_result_reg <= alu_result;
        rsp_valid_reg  <= owner_oh;
      end else if (timeout_hit) begin
        rsp_result_reg <= '0;
        rsp_valid_reg  <= owner_oh;
      end
    end
  end

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? 16 : 8;

  logic [CNT_W-1:0] wait_cnt_reg;
  logic             rsp_err_reg;

  // A done in the terminal-count cycle wins over the timeout.
  assign timeout_hit = (state_reg == ST_WAIT) && !alu_done &&
                       (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt_reg <= '0;
      rsp_err_reg  <= 1'b0;
    end else begin
      wait_cnt_reg <= (state_reg == ST_WAIT) ? wait_cnt_reg + 1'b1 : '0;
      rsp_err_reg  <= timeout_hit;
    end
  end

  assign rsp_err = rsp_err_reg;
`else
  assign timeout_hit = 1'b0;

  // TIMEOUT_CYCLES stays referenced so both builds share one parameter list.
  if (TIMEOUT_CYCLES >= 0) begin : g_no_timeout
    assign rsp_err = 1'b0;
  end
`endif

  assign req_ready  = ((state_reg == ST_IDLE) && rst) ? (grant_oh & req_valid) : '0;
  assign alu_valid  = alu_valid_reg;
  assign alu_op     = alu_op_reg;
  assign alu_a      = alu_a_reg;
  assign alu_b      = alu_b_reg;
  assign rsp_valid  = rsp_valid_reg;
  assign rsp_result = rsp_result_reg;
  assign busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Randomized bench for alu_req_arbiter: requesters and the ALU are driven from here and every
// cycle the outputs are compared against a transaction-level reference of the arbiter.
module tb_alu_req_arbiter;
  localparam int N   = 4;
  localparam int OPW = 3;
  localparam int INW = 8;
  localparam int RW  = 16;
  localparam int TMO = 10;
`ifdef ALU_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*OPW-1:0] req_op;
  logic [N*INW-1:0] req_a;
  logic [N*INW-1:0] req_b;
  logic             alu_valid;
  logic             alu_ready;
  logic [OPW-1:0]   alu_op;
  logic [INW-1:0]   alu_a;
  logic [INW-1:0]   alu_b;
  logic             alu_done;
  logic [RW-1:0]    alu_result;
  logic [N-1:0]     rsp_valid;
  logic [RW-1:0]    rsp_result;
  logic             rsp_err;
  logic             busy;

  always #5 clk = ~clk;

  alu_req_arbiter #(
    .NUM_REQ(N), .ALU_OP_WIDTH(OPW), .ALU_IN_WIDTH(INW),
    .ALU_OUT_RESULT_WIDTH(RW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_err(rsp_err),
    .busy(busy)
  );

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Requester agents.
  bit           pend [N];
  logic [OPW-1:0] r_op [N];
  logic [INW-1:0] r_a  [N];
  logic [INW-1:0] r_b  [N];

  // Reference: one transaction in flight, described by its phase flags.
  bit             m_active, m_issued, m_resp, m_err;
  int             m_g, m_last, m_wait;
  logic [OPW-1:0] m_op;
  logic [INW-1:0] m_a, m_b;
  logic [RW-1:0]  m_res;

  // Events of the current cycle, applied to the reference at the next edge.
  int            exp_grant;
  bit            ev_hs, ev_done;
  logic [RW-1:0] ev_res;

  int p_req, rst_pm, n_txn, n_rsp_dut, n_rsp_model, rr_prev;
  bit allow_wd, no_done, hold_rst, rr_on, rst_in_wait, force_done;

  function automatic int rr_pick(input int last);
    for (int k = 1; k <= N; k++) begin
      if (pend[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int idx);
    logic [N-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) if (k == idx) v[k] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_active = 0; m_issued = 0; m_resp = 0; m_err = 0; m_wait = 0;
    m_last = N - 1; m_g = 0; m_op = '0; m_a = '0; m_b = '0; m_res = '0;
    exp_grant = -1; ev_hs = 0; ev_done = 0;
  endtask

  task automatic step();
    logic [N-1:0] exp_rdy;
    int idx;
    @(posedge clk);
    // Absorb what happened at this edge.
    if (!rst) begin
      model_reset();
    end else begin
      if (m_resp) begin
        m_active = 0; m_resp = 0; m_err = 0;
      end else if (m_active && !m_issued) begin
        if (ev_hs) begin
          m_issued = 1; m_wait = 0;
          if (ev_done) begin m_resp = 1; m_res = ev_res; end
        end
      end else if (m_active) begin
        if (ev_done) begin
          m_resp = 1; m_res = ev_res;
        end else begin
          m_wait++;
          if (TMO_EN && m_wait == TMO) begin m_resp = 1; m_res = '0; m_err = 1; end
        end
      end
      if (exp_grant >= 0) begin
        m_active = 1; m_issued = 0; m_g = exp_grant; m_last = exp_grant;
        m_op = r_op[m_g]; m_a = r_a[m_g]; m_b = r_b[m_g];
        pend[m_g] = 0;
        n_txn++;
        $display("txn %0d: requester %0d op=%0d a=%02h b=%02h", n_txn, m_g, m_op, m_a, m_b);
      end
    end

    #1;
    // Requesters: idle buses carry garbage; a pending request holds until granted.
    for (int i = 0; i < N; i++) begin
      if (!pend[i]) begin
        r_op[i] = OPW'($urandom); r_a[i] = INW'($urandom); r_b[i] = INW'($urandom);
        if ($urandom_range(0, 99) < p_req) pend[i] = 1;
      end else if (allow_wd && $urandom_range(0, 99) < 2) begin
        pend[i] = 0;
      end
      req_valid[i] = pend[i];
      req_op[i*OPW +: OPW] = r_op[i];
      req_a[i*INW +: INW]  = r_a[i];
      req_b[i*INW +: INW]  = r_b[i];
    end
    // ALU side.
    alu_ready  = 1'b0;
    alu_done   = 1'b0;
    alu_result = RW'($urandom);
    if (m_active && !m_resp && !m_issued) begin
      alu_ready = ($urandom_range(0, 1) == 1);
      if (alu_ready && !no_done) alu_done = ($urandom_range(0, 3) == 0);
    end else if (m_active && !m_resp) begin
      if (!no_done) alu_done = ($urandom_range(0, 2) == 0);
    end else begin
      alu_done = force_done || ($urandom_range(0, 4) == 0);
    end
    force_done = 0;
    // Reset: held, random, or aimed at a transaction waiting for done.
    rst = 1'b1;
    if (hold_rst || (rst_pm > 0 && $urandom_range(0, 999) < rst_pm)) rst = 1'b0;
    if (rst_in_wait && m_active && m_issued && !m_resp) begin
      rst = 1'b0; rst_in_wait = 0; force_done = 1;
    end

    #1;
    exp_grant = -1;
    if (rst && !m_active) exp_grant = rr_pick(m_last);
    exp_rdy = (exp_grant >= 0) ? onehot(exp_grant) : '0;
    check_eq("req_ready", req_ready, exp_rdy);
    check_eq("busy", busy, m_active);
    check_eq("alu_valid", alu_valid, m_active && !m_issued && !m_resp);
    check_eq("alu_op", alu_op, m_op);
    check_eq("alu_a", alu_a, m_a);
    check_eq("alu_b", alu_b, m_b);
    check_eq("rsp_valid", rsp_valid, m_resp ? onehot(m_g) : '0);
    check_eq("rsp_result", rsp_result, m_res);
    check_eq("rsp_err", rsp_err, m_resp && m_err);
    if (rsp_valid != '0) n_rsp_dut++;
    if (m_resp) n_rsp_model++;
    // With everyone continuously requesting, grants must step by one.
    if (rr_on && req_ready != '0) begin
      idx = -1;
      for (int k = 0; k < N; k++) if (req_ready[k]) idx = k;
      if (rr_prev >= 0) check_eq("rr_order", idx, (rr_prev + 1) % N);
      rr_prev = idx;
    end
    ev_hs   = rst && alu_ready && m_active && !m_issued && !m_resp;
    ev_done = alu_done;
    ev_res  = alu_result;
  endtask

  initial begin
    rst = 1'b0; req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
    alu_ready = 1'b0; alu_done = 1'b0; alu_result = '0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 0; r_op[i] = '0; r_a[i] = '0; r_b[i] = '0;
    end
    model_reset();
    n_txn = 0; n_rsp_dut = 0; n_rsp_model = 0; rr_prev = -1;
    allow_wd = 0; no_done = 0; rr_on = 0; rst_in_wait = 0; force_done = 0;
    p_req = 0; rst_pm = 0; hold_rst = 1;
    repeat (2) @(posedge clk);
    repeat (3) step();
    hold_rst = 0;

    // Mixed traffic with withdrawals, spurious done pulses and random resets.
    p_req = 30; allow_wd = 1; rst_pm = 4;
    repeat (1500) step();

    // Saturated traffic for round-robin order.
    p_req = 100; allow_wd = 0; rst_pm = 0; rr_on = 1; rr_prev = -1;
    repeat (200) step();
    rr_on = 0;

    // Reset while waiting for done, followed by a late done pulse.
    p_req = 50;
    repeat (3) begin
      rst_in_wait = 1;
      repeat (40) step();
    end
    rst_in_wait = 0;

`ifdef ALU_ARB_TIMEOUT_EN
    no_done = 1; p_req = 20;
    repeat (300) step();
    no_done = 0;
`endif

    p_req = 30; allow_wd = 1; rst_pm = 4;
    repeat (300) step();

    check_eq("rsp_count", n_rsp_dut, n_rsp_model);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
